// File: rtl/fc_layer_pipe.sv
// Pipelined fully-connected neuron: LANES unsigned x signed products per beat, BEATS beats
// accumulated on a bias, then shifted and clamped. Define FC_RELU_EN for an unsigned ReLU clamp.
module fc_layer_pipe #(
    parameter int DW        = 8,
    parameter int LANES     = 7,
    parameter int BEATS     = 16,
    parameter int ACC_DW    = 24,
    parameter int OUT_DW    = 8,
    parameter int OUT_SHIFT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   data_layer_in,
    input  logic [LANES*DW-1:0]   data_weight_in,
    input  logic [ACC_DW-1:0]     bias_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_DW-1:0]     data_out,
    output logic                  acc_sat,
    output logic                  busy
);

    localparam int PW    = 2*DW + 1;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic signed [ACC_DW-1:0] ACC_MAX = {1'b0, {(ACC_DW-1){1'b1}}};
    localparam logic signed [ACC_DW-1:0] ACC_MIN = {1'b1, {(ACC_DW-1){1'b0}}};
`ifdef FC_RELU_EN
    localparam logic signed [ACC_DW-1:0] OUT_HI = {{(ACC_DW-OUT_DW){1'b0}}, {OUT_DW{1'b1}}};
`else
    localparam logic signed [ACC_DW-1:0] OUT_HI = {{(ACC_DW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
    localparam logic signed [ACC_DW-1:0] OUT_LO = {{(ACC_DW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Returns {overflow, saturated a+b}.
    function automatic logic [ACC_DW:0] sat_add(input logic signed [ACC_DW-1:0] a,
                                                input logic signed [ACC_DW-1:0] b);
        logic signed [ACC_DW-1:0] s;
        logic                     ovf;
        s   = a + b;
        ovf = (a[ACC_DW-1] == b[ACC_DW-1]) && (s[ACC_DW-1] != a[ACC_DW-1]);
        s   = ovf ? (a[ACC_DW-1] ? ACC_MIN : ACC_MAX) : s;
        return {ovf, s};
    endfunction

    function automatic logic [OUT_DW-1:0] clamp_out(input logic signed [ACC_DW-1:0] acc);
        logic signed [ACC_DW-1:0] r;
        logic [OUT_DW-1:0]        res;
        r = acc >>> OUT_SHIFT;
`ifdef FC_RELU_EN
        if (r[ACC_DW-1]) begin
            res = {OUT_DW{1'b0}};
        end else if (r > OUT_HI) begin
            res = {OUT_DW{1'b1}};
        end else begin
            res = r[OUT_DW-1:0];
        end
`else
        if (r < OUT_LO) begin
            res = OUT_LO[OUT_DW-1:0];
        end else if (r > OUT_HI) begin
            res = OUT_HI[OUT_DW-1:0];
        end else begin
            res = r[OUT_DW-1:0];
        end
`endif
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               drain_q, drain_d;
    logic [CNT_W-1:0]         beat_cnt_q;
    logic signed [PW-1:0]     prod_s [LANES];
    logic signed [PW-1:0]     s1_q   [LANES];
    logic                     s1_vld_q;
    logic signed [ACC_DW-1:0] sum_s;
    logic signed [ACC_DW-1:0] s2_q;
    logic                     s2_vld_q;
    logic signed [ACC_DW-1:0] acc_q, acc_d;
    logic                     sat_q, sat_d;
    logic [ACC_DW:0]          add_s;
    logic                     out_valid_q;
    logic [OUT_DW-1:0]        data_out_q;
    logic                     acc_sat_q;
    logic                     accept_s;
    logic                     first_s;
    logic                     load_out_s;

    assign in_ready   = (state_q == IDLE) || (state_q == ACCUM);
    assign busy       = (state_q != IDLE);
    assign accept_s   = in_valid && in_ready;
    assign first_s    = accept_s && (state_q == IDLE);
    // The extra DRAIN cycle lets the last beat land in acc before the output register samples it.
    assign load_out_s = (state_q == DRAIN) && (drain_q == 2'd2);
    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign acc_sat    = acc_sat_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (BEATS == 1) ? DRAIN : ACCUM;
                    drain_d = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && (beat_cnt_q == LAST_CNT)) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd2) begin
                    state_d = OUT;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
                drain_d = 2'd0;
            end
        endcase
    end

    // Beat counter within a neuron.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= {CNT_W{1'b0}};
        end else if (first_s) begin
            beat_cnt_q <= CNT_W'(1);
        end else if (accept_s) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    // Lane products; activation zero-extended so the multiply is signed throughout.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_s[i] = PW'($signed({1'b0, data_layer_in[(LANES-1-i)*DW +: DW]}))
                      * PW'($signed(data_weight_in[(LANES-1-i)*DW +: DW]));
        end
    end

    // S1: product registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                s1_q[i] <= {PW{1'b0}};
            end
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= accept_s;
            if (accept_s) begin
                s1_q <= prod_s;
            end
        end
    end

    // Lane reduction, sign-extended to accumulator width.
    always_comb begin
        sum_s = {ACC_DW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + ACC_DW'(s1_q[i]);
        end
    end

    // S2: beat-sum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_q     <= {ACC_DW{1'b0}};
            s2_vld_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_q <= sum_s;
            end
        end
    end

    // S3: bias load on the first beat, otherwise saturating accumulate.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        add_s = sat_add(acc_q, s2_q);
        if (first_s) begin
            acc_d = bias_in;
            sat_d = 1'b0;
        end else if (s2_vld_q) begin
            acc_d = add_s[ACC_DW-1:0];
            sat_d = sat_q | add_s[ACC_DW];
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and sticky saturation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= {ACC_DW{1'b0}};
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    // Output register, held until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            data_out_q  <= {OUT_DW{1'b0}};
            acc_sat_q   <= 1'b0;
        end else if (load_out_s) begin
            out_valid_q <= 1'b1;
            data_out_q  <= clamp_out(acc_q);
            acc_sat_q   <= sat_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_layer_pipe.sv
// Scoreboard bench for fc_layer_pipe: BEATS=4 main instance plus a BEATS=1 instance.
module tb_fc_layer_pipe;

    localparam int DW = 8, LANES = 7, BEATS = 4, ACC_DW = 24, OUT_DW = 8, OUT_SHIFT = 7;

    typedef struct packed {
        logic [OUT_DW-1:0] data;
        logic              sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, out_ready;
    logic [LANES*DW-1:0] act, wgt, va, vw;
    logic [ACC_DW-1:0]   bias;
    logic in_ready, out_valid, acc_sat, busy;
    logic [OUT_DW-1:0] data_out;

    logic in_valid1, out_ready1;
    logic [LANES*DW-1:0] act1, wgt1;
    logic [ACC_DW-1:0]   bias1;
    logic in_ready1, out_valid1, acc_sat1, busy1;
    logic [OUT_DW-1:0] data_out1;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    fc_layer_pipe #(.DW(DW), .LANES(LANES), .BEATS(BEATS), .ACC_DW(ACC_DW),
                    .OUT_DW(OUT_DW), .OUT_SHIFT(OUT_SHIFT)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_layer_in(act), .data_weight_in(wgt), .bias_in(bias),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .acc_sat(acc_sat), .busy(busy));

    fc_layer_pipe #(.DW(DW), .LANES(LANES), .BEATS(1), .ACC_DW(ACC_DW),
                    .OUT_DW(OUT_DW), .OUT_SHIFT(OUT_SHIFT)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .data_layer_in(act1), .data_weight_in(wgt1), .bias_in(bias1),
        .out_valid(out_valid1), .out_ready(out_ready1), .data_out(data_out1),
        .acc_sat(acc_sat1), .busy(busy1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [LANES*DW-1:0] splat(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    // Reference: exact beat sums, saturating accumulation, floor shift, clamp.
    task automatic model_push(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] w,
                              input logic [ACC_DW-1:0] b, input int nb);
        longint amax = longint'(2**(ACC_DW-1)) - 1;
        longint amin = -longint'(2**(ACC_DW-1));
        longint acc, s, r, lo, hi;
        logic [DW-1:0]        as;
        logic signed [DW-1:0] ws;
        exp_t x;
        acc   = longint'($signed(b));
        x.sat = 1'b0;
        for (int k = 0; k < nb; k++) begin
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                as = a[i*DW +: DW];
                ws = w[i*DW +: DW];
                s += longint'(as) * longint'(ws);
            end
            acc += s;
            if (acc > amax) begin acc = amax; x.sat = 1'b1; end
            else if (acc < amin) begin acc = amin; x.sat = 1'b1; end
        end
        r = acc >>> OUT_SHIFT;
`ifdef FC_RELU_EN
        lo = 0;
        hi = longint'(2**OUT_DW) - 1;
`else
        lo = -longint'(2**(OUT_DW-1));
        hi = longint'(2**(OUT_DW-1)) - 1;
`endif
        if (r < lo) r = lo;
        else if (r > hi) r = hi;
        x.data = OUT_DW'(r);
        sb.push_back(x);
    endtask

    task automatic send_neuron(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] w,
                               input logic [ACC_DW-1:0] b, input int gap);
        act = a; wgt = w; bias = b;
        for (int k = 0; k < BEATS; k++) begin
            if (k > 0) begin
                bias = ~b;
                repeat (gap) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            check("in_ready_beat", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        model_push(a, w, b, BEATS);
    endtask

    task automatic wait_out(input int stall);
        int cnt = 0;
        logic [OUT_DW-1:0] d0;
        check("in_ready_drain", in_ready, 0);
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("out_latency", cnt, 3);
        check("busy_out", busy, 1);
        d0 = data_out;
        if (stall > 0) out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_data", data_out, d0);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("data_out", data_out, e.data);
            check("acc_sat", acc_sat, e.sat);
        end
        @(posedge clk); #1;
        check("valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        act = '0; wgt = '0; bias = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; act1 = '0; wgt1 = '0; bias1 = '0;
        for (int i = 0; i < LANES; i++) begin
            va[i*DW +: DW] = DW'(i*37 + 1);
            vw[i*DW +: DW] = DW'(i*19 - 60);
        end
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_acc_sat", acc_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        send_neuron(splat(8'd10), splat(8'd3), 24'd0, 0);           wait_out(0);
        send_neuron(splat(8'd10), splat(8'hFD), 24'd0, 0);          wait_out(0);
        send_neuron(splat(8'd255), splat(8'd127), 24'd0, 0);        wait_out(0);
        send_neuron(splat(8'd255), splat(8'd127), 24'd8388600, 0);  wait_out(0);
        send_neuron(splat(8'd10), splat(8'd3), 24'd0, 0);           wait_out(0);
        send_neuron(va, vw, 24'hFFFC18, 0);                         wait_out(0);
        send_neuron(splat(8'd10), splat(8'd3), 24'd0, 2);           wait_out(5);

        // Abort a neuron after two beats.
        act = splat(8'd10); wgt = splat(8'd3); bias = 24'd0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_data_out", data_out, 0);
        check("abort_acc_sat", acc_sat, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1 reset = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("abort_no_output", n, 0);
        send_neuron(splat(8'd10), splat(8'd3), 24'd0, 0);           wait_out(0);

        // Single-beat configuration.
        act1 = splat(8'd50); wgt1 = '0; bias1 = 24'd128;
        in_valid1 = 1'b1;
        check("b1_in_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b1_latency", n, 3);
        check("b1_data_out", data_out1, 1);
        check("b1_acc_sat", acc_sat1, 0);
        @(posedge clk); #1;
        check("b1_valid_after_hs", out_valid1, 0);
        check("b1_idle", busy1, 0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
